// File: rtl/minmax_tree_pipe.sv
// rtl/minmax_tree_pipe.sv - pipelined N-input min/max selector with valid/ready handshake
//
// Purpose: selects the minimum (in_mode=0) or maximum (in_mode=1) of NUM_IN
// elements through a registered pairwise compare tree, one tree level per
// pipeline stage, and reports the winning value with its original input index.
//
// Ports:
//   clk        single clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input vector valid
//   in_ready   block can accept the input vector this cycle
//   in_data    NUM_IN elements, element i at [i*DATA_W +: DATA_W]
//   in_mode    0 = minimum, 1 = maximum, sampled with in_data
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   selected value
//   out_idx    index of the selected element
//   out_mode   mode the result was computed with

module minmax_tree_pipe #(
  parameter int DATA_W = 8,
  parameter int NUM_IN = 8,
  parameter int SIGNED = 0,
  localparam int LEVELS = $clog2(NUM_IN),
  localparam int IDX_W  = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic                     in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_mode
);

  // Number of live entries at tree level k (level 0 = the raw inputs).
  function automatic int f_cnt(input int k);
    return (NUM_IN + (1 << k) - 1) >> k;
  endfunction

  // True when the right-hand candidate b beats the left-hand candidate a.
  // a always covers lower original indices than b, so ties keep a.
  function automatic logic f_b_wins(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b,
                                    input logic              pa,
                                    input logic              pb,
                                    input logic              mode);
    logic b_lt;
    logic b_gt;
    if (SIGNED != 0) begin
      b_lt = $signed(b) < $signed(a);
      b_gt = $signed(b) > $signed(a);
    end else begin
      b_lt = b < a;
      b_gt = b > a;
    end
    if (!pa)      f_b_wins = 1'b1;
    else if (!pb) f_b_wins = 1'b0;
    else          f_b_wins = mode ? b_gt : b_lt;
  endfunction

  // Stage registers; only the first f_cnt(k) entries of stage k carry data.
  logic [DATA_W-1:0] r_val  [1:LEVELS][0:NUM_IN-1];
  logic [IDX_W-1:0]  r_idx  [1:LEVELS][0:NUM_IN-1];
  logic              r_pres [1:LEVELS][0:NUM_IN-1];
  logic              r_mode [1:LEVELS];
  logic              r_v    [1:LEVELS];

  // Source (previous level) and next-state views for each stage.
  logic [DATA_W-1:0] w_src_val  [1:LEVELS][0:NUM_IN-1];
  logic [IDX_W-1:0]  w_src_idx  [1:LEVELS][0:NUM_IN-1];
  logic              w_src_pres [1:LEVELS][0:NUM_IN-1];
  logic              w_src_mode [1:LEVELS];
  logic              w_src_v    [1:LEVELS];
  logic [DATA_W-1:0] w_nxt_val  [1:LEVELS][0:NUM_IN-1];
  logic [IDX_W-1:0]  w_nxt_idx  [1:LEVELS][0:NUM_IN-1];
  logic              w_nxt_pres [1:LEVELS][0:NUM_IN-1];
  logic [LEVELS:1]   w_ready;

  // Backpressure chain: a stage may load if it is empty or its successor
  // can take its contents this cycle.
  always_comb begin
    w_ready = '0;
    w_ready[LEVELS] = !r_v[LEVELS] || out_ready;
    for (int k = LEVELS - 1; k >= 1; k--) begin
      w_ready[k] = !r_v[k] || w_ready[k+1];
    end
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int PC = f_cnt(k - 1);

    if (k == 1) begin : g_first
      assign w_src_v[k]    = in_valid;
      assign w_src_mode[k] = in_mode;
      for (genvar i = 0; i < NUM_IN; i++) begin : g_leaf
        assign w_src_val[k][i]  = in_data[i*DATA_W +: DATA_W];
        assign w_src_idx[k][i]  = IDX_W'(i);
        assign w_src_pres[k][i] = 1'b1;
      end
    end else begin : g_inner
      assign w_src_v[k]    = r_v[k-1];
      assign w_src_mode[k] = r_mode[k-1];
      for (genvar i = 0; i < NUM_IN; i++) begin : g_fwd
        assign w_src_val[k][i]  = r_val[k-1][i];
        assign w_src_idx[k][i]  = r_idx[k-1][i];
        assign w_src_pres[k][i] = r_pres[k-1][i];
      end
    end

    for (genvar j = 0; j < NUM_IN; j++) begin : g_ent
      if (2*j + 1 < PC) begin : g_pair
        logic w_bwin;
        assign w_bwin = f_b_wins(w_src_val[k][2*j], w_src_val[k][2*j+1],
                                 w_src_pres[k][2*j], w_src_pres[k][2*j+1],
                                 w_src_mode[k]);
        assign w_nxt_val[k][j]  = w_bwin ? w_src_val[k][2*j+1] : w_src_val[k][2*j];
        assign w_nxt_idx[k][j]  = w_bwin ? w_src_idx[k][2*j+1] : w_src_idx[k][2*j];
        assign w_nxt_pres[k][j] = w_src_pres[k][2*j] | w_src_pres[k][2*j+1];
      end else if (2*j < PC) begin : g_pass
        // Odd entry count: the last entry rides through this level unchanged.
        assign w_nxt_val[k][j]  = w_src_val[k][2*j];
        assign w_nxt_idx[k][j]  = w_src_idx[k][2*j];
        assign w_nxt_pres[k][j] = w_src_pres[k][2*j];
      end else begin : g_none
        assign w_nxt_val[k][j]  = '0;
        assign w_nxt_idx[k][j]  = '0;
        assign w_nxt_pres[k][j] = 1'b0;
      end
    end
  end

  // Valid flags follow the ready chain so bubbles collapse; payload only
  // moves with a valid transaction so a stalled or idle stage keeps its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= LEVELS; k++) begin
        r_v[k]    <= 1'b0;
        r_mode[k] <= 1'b0;
        for (int j = 0; j < NUM_IN; j++) begin
          r_val[k][j]  <= '0;
          r_idx[k][j]  <= '0;
          r_pres[k][j] <= 1'b0;
        end
      end
    end else begin
      for (int k = 1; k <= LEVELS; k++) begin
        if (w_ready[k]) begin
          r_v[k] <= w_src_v[k];
          if (w_src_v[k]) begin
            r_mode[k] <= w_src_mode[k];
            for (int j = 0; j < NUM_IN; j++) begin
              r_val[k][j]  <= w_nxt_val[k][j];
              r_idx[k][j]  <= w_nxt_idx[k][j];
              r_pres[k][j] <= w_nxt_pres[k][j];
            end
          end
        end
      end
    end
  end

  assign in_ready  = w_ready[1];
  assign out_valid = r_v[LEVELS];
  assign out_data  = r_val[LEVELS][0];
  assign out_idx   = r_idx[LEVELS][0];
  assign out_mode  = r_mode[LEVELS];

endmodule

// File: tb/tb_minmax_tree_pipe.sv
// tb/tb_minmax_tree_pipe.sv - self-checking bench for minmax_tree_pipe
module tb_minmax_tree_pipe;

  typedef struct packed {
    logic [7:0] val;
    logic [2:0] idx;
    logic       mode;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // NUM_IN=8 unsigned instance
  logic        v8, m8, ordy8;
  logic [63:0] d8;
  logic        r8, ov8, om8;
  logic [7:0]  od8;
  logic [2:0]  oi8;
  // NUM_IN=3 instance
  logic        v3, m3, ordy3;
  logic [23:0] d3;
  logic        r3, ov3, om3;
  logic [7:0]  od3;
  logic [1:0]  oi3;
  // NUM_IN=5 signed and unsigned instances sharing inputs
  logic        v5, m5, ordy5;
  logic [39:0] d5;
  logic        r5s, ov5s, om5s, r5u, ov5u, om5u;
  logic [7:0]  od5s, od5u;
  logic [2:0]  oi5s, oi5u;

  int checks = 0;
  int failures = 0;

  minmax_tree_pipe #(.DATA_W(8), .NUM_IN(8), .SIGNED(0)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_data(d8), .in_mode(m8),
    .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .out_idx(oi8), .out_mode(om8));

  minmax_tree_pipe #(.DATA_W(8), .NUM_IN(3), .SIGNED(0)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(r3), .in_data(d3), .in_mode(m3),
    .out_valid(ov3), .out_ready(ordy3), .out_data(od3), .out_idx(oi3), .out_mode(om3));

  minmax_tree_pipe #(.DATA_W(8), .NUM_IN(5), .SIGNED(1)) dut5s (
    .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(r5s), .in_data(d5), .in_mode(m5),
    .out_valid(ov5s), .out_ready(ordy5), .out_data(od5s), .out_idx(oi5s), .out_mode(om5s));

  minmax_tree_pipe #(.DATA_W(8), .NUM_IN(5), .SIGNED(0)) dut5u (
    .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(r5u), .in_data(d5), .in_mode(m5),
    .out_valid(ov5u), .out_ready(ordy5), .out_data(od5u), .out_idx(oi5u), .out_mode(om5u));

  // Reference: linear scan, strict comparison keeps the lowest index on ties.
  function automatic res_t ref_sel(input logic [63:0] d, input int n, input logic mode, input bit sgn);
    res_t r;
    int best = 0;
    int kb, ki;
    logic [7:0] eb, ei;
    for (int i = 1; i < n; i++) begin
      eb = d[best*8 +: 8];
      ei = d[i*8 +: 8];
      kb = sgn ? int'($signed(eb)) : int'(eb);
      ki = sgn ? int'($signed(ei)) : int'(ei);
      if (mode ? (ki > kb) : (ki < kb)) best = i;
    end
    r.val  = d[best*8 +: 8];
    r.idx  = 3'(best);
    r.mode = mode;
    return r;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    v8 = 0; m8 = 0; d8 = '0; ordy8 = 1;
    v3 = 0; m3 = 0; d3 = '0; ordy3 = 1;
    v5 = 0; m5 = 0; d5 = '0; ordy5 = 1;
    repeat (2) @(negedge clk);
    checks++; if ({ov8, od8, oi8, om8} !== 13'd0) begin failures++; $display("FAIL reset_out8 got=%h exp=0", {ov8, od8, oi8, om8}); end
    checks++; if (r8 !== 1'b1) begin failures++; $display("FAIL reset_ready8 got=%b exp=1", r8); end
    checks++; if ({ov3, r3, ov5s, ov5u} !== 4'b0100) begin failures++; $display("FAIL reset_small got=%b exp=0100", {ov3, r3, ov5s, ov5u}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({ov8, r8} !== 2'b01) begin failures++; $display("FAIL post_reset got=%b exp=01", {ov8, r8}); end
  endtask

  task automatic test_n3_min;
    @(posedge clk); #1;
    d3 = {8'd7, 8'd4, 8'd9}; m3 = 0; v3 = 1; ordy3 = 1;
    @(negedge clk);
    checks++; if (r3 !== 1'b1) begin failures++; $display("FAIL n3_ready got=%b exp=1", r3); end
    @(posedge clk); #1; v3 = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(posedge clk);
      @(negedge clk);
      checks++; if (ov3 !== (c == 2)) begin failures++; $display("FAIL n3_valid c=%0d got=%b exp=%b", c, ov3, c == 2); end
      if (c == 2) begin
        checks++; if ({od3, oi3, om3} !== {8'd4, 2'd1, 1'b0}) begin failures++; $display("FAIL n3_result got=%0d/%0d/%0d exp=4/1/0", od3, oi3, om3); end
      end
    end
  endtask

  task automatic test_tie_mode_alternate;
    @(posedge clk); #1;
    d8 = {8'd1, 8'd9, 8'd5, 8'd0, 8'd200, 8'd17, 8'd200, 8'd3}; m8 = 1; v8 = 1; ordy8 = 1;
    @(posedge clk); #1; m8 = 0;
    @(posedge clk); #1; v8 = 0;
    for (int c = 2; c <= 6; c++) begin
      if (c > 2) @(posedge clk);
      @(negedge clk);
      checks++; if (ov8 !== (c == 3 || c == 4)) begin failures++; $display("FAIL tie_valid c=%0d got=%b exp=%b", c, ov8, c == 3 || c == 4); end
      if (c == 3) begin
        checks++; if ({od8, oi8, om8} !== {8'd200, 3'd1, 1'b1}) begin failures++; $display("FAIL tie_max got=%0d/%0d/%0d exp=200/1/1", od8, oi8, om8); end
      end
      if (c == 4) begin
        checks++; if ({od8, oi8, om8} !== {8'd0, 3'd4, 1'b0}) begin failures++; $display("FAIL tie_min got=%0d/%0d/%0d exp=0/4/0", od8, oi8, om8); end
      end
    end
  endtask

  task automatic test_signed;
    logic [10:0] exp_s, exp_u;
    for (int m = 0; m < 2; m++) begin
      exp_s = (m == 0) ? {8'h80, 3'd1} : {8'h7F, 3'd2};
      exp_u = (m == 0) ? {8'h00, 3'd4} : {8'hFF, 3'd3};
      @(posedge clk); #1;
      d5 = {8'h00, 8'hFF, 8'h7F, 8'h80, 8'h10}; m5 = m[0]; v5 = 1; ordy5 = 1;
      @(posedge clk); #1; v5 = 0;
      for (int c = 1; c <= 3; c++) begin
        if (c > 1) @(posedge clk);
        @(negedge clk);
        checks++; if ({ov5s, ov5u} !== {2{c == 3}}) begin failures++; $display("FAIL sgn_valid m=%0d c=%0d got=%b%b", m, c, ov5s, ov5u); end
        if (c == 3) begin
          checks++; if ({od5s, oi5s} !== exp_s) begin failures++; $display("FAIL sgn_signed m=%0d got=%h/%0d exp=%h/%0d", m, od5s, oi5s, exp_s[10:3], exp_s[2:0]); end
          checks++; if ({od5u, oi5u} !== exp_u) begin failures++; $display("FAIL sgn_unsigned m=%0d got=%h/%0d exp=%h/%0d", m, od5u, oi5u, exp_u[10:3], exp_u[2:0]); end
        end
      end
    end
  endtask

  task automatic test_bubbles;
    logic [9:0] pat;
    res_t exp_r [10];
    pat = 10'b0000000101;
    ordy8 = 1;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      v8 = pat[t]; d8 = {$urandom, $urandom}; m8 = 1'($urandom_range(0, 1));
      exp_r[t] = ref_sel(d8, 8, m8, 0);
      @(negedge clk);
      checks++; if (ov8 !== ((t >= 3) && pat[t-3])) begin failures++; $display("FAIL bubble_valid t=%0d got=%b", t, ov8); end
      if ((t >= 3) && pat[t-3]) begin
        checks++; if ({od8, oi8, om8} !== exp_r[t-3]) begin failures++; $display("FAIL bubble_data t=%0d got=%h exp=%h", t, {od8, oi8, om8}, exp_r[t-3]); end
      end
    end
    v8 = 0;
  endtask

  task automatic test_backpressure;
    res_t q[$];
    res_t e;
    logic [63:0] vec [6];
    logic vmode [6];
    int sent = 0, got = 0;
    bit hold = 0;
    logic [11:0] held;
    for (int i = 0; i < 6; i++) begin vec[i] = {$urandom, $urandom}; vmode[i] = 1'($urandom_range(0, 1)); end
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(posedge clk); #1;
      ordy8 = (cyc >= 5);
      v8 = (sent < 6);
      if (sent < 6) begin d8 = vec[sent]; m8 = vmode[sent]; end
      @(negedge clk);
      checks++; if (r8 !== ((q.size() < 3) || ordy8)) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b inflight=%0d", cyc, r8, q.size()); end
      if (hold) begin
        checks++; if ({od8, oi8, om8} !== held) begin failures++; $display("FAIL bp_stable cyc=%0d got=%h exp=%h", cyc, {od8, oi8, om8}, held); end
      end
      if (cyc == 4) begin
        checks++; if (sent != 3 || r8 !== 1'b0) begin failures++; $display("FAIL bp_fill accepted=%0d ready=%b exp=3/0", sent, r8); end
      end
      if (ov8 && ordy8) begin
        checks++;
        if (q.size() == 0) begin failures++; $display("FAIL bp_spurious cyc=%0d got=%h exp=none", cyc, {od8, oi8, om8}); end
        else begin
          e = q.pop_front(); got++;
          if ({od8, oi8, om8} !== e) begin failures++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", cyc, {od8, oi8, om8}, e); end
        end
      end
      if (v8 && r8) begin q.push_back(ref_sel(d8, 8, m8, 0)); sent++; end
      hold = ov8 && !ordy8;
      held = {od8, oi8, om8};
    end
    v8 = 0;
    checks++; if (got != 6 || q.size() != 0) begin failures++; $display("FAIL bp_count got=%0d exp=6 left=%0d", got, q.size()); end
  endtask

  task automatic test_random_stream;
    res_t q[$];
    res_t e;
    bit hold = 0;
    logic [11:0] held;
    for (int cyc = 0; cyc < 420; cyc++) begin
      @(posedge clk); #1;
      ordy8 = (cyc >= 400) || ($urandom_range(0, 9) < 7);
      v8 = (cyc < 400) && ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 8; i++) d8[i*8 +: 8] = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      m8 = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++; if (r8 !== ((q.size() < 3) || ordy8)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b inflight=%0d", cyc, r8, q.size()); end
      if (hold) begin
        checks++; if ({od8, oi8, om8} !== held) begin failures++; $display("FAIL rnd_stable cyc=%0d got=%h exp=%h", cyc, {od8, oi8, om8}, held); end
      end
      if (ov8 && ordy8) begin
        checks++;
        if (q.size() == 0) begin failures++; $display("FAIL rnd_spurious cyc=%0d got=%h exp=none", cyc, {od8, oi8, om8}); end
        else begin
          e = q.pop_front();
          if ({od8, oi8, om8} !== e) begin failures++; $display("FAIL rnd_data cyc=%0d got=%h exp=%h", cyc, {od8, oi8, om8}, e); end
        end
      end
      if (v8 && r8) q.push_back(ref_sel(d8, 8, m8, 0));
      hold = ov8 && !ordy8;
      held = {od8, oi8, om8};
    end
    v8 = 0;
    checks++; if (q.size() != 0) begin failures++; $display("FAIL rnd_drain left=%0d exp=0", q.size()); end
  endtask

  task automatic test_reset_midflight;
    ordy8 = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      v8 = 1; d8 = {$urandom, $urandom}; m8 = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1; v8 = 0;
    checks++; if (ov8 !== 1'b1) begin failures++; $display("FAIL mid_inflight got=%b exp=1", ov8); end
    #2; rst_n = 1'b0; #1;
    checks++; if ({ov8, r8} !== 2'b01) begin failures++; $display("FAIL mid_reset_edge got=%b exp=01", {ov8, r8}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(posedge clk); #1;
      v8 = (c == 0); d8 = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}; m8 = 0;
      @(negedge clk);
      checks++; if (ov8 !== (c == 3)) begin failures++; $display("FAIL mid_valid c=%0d got=%b exp=%b", c, ov8, c == 3); end
      if (c == 3) begin
        checks++; if ({od8, oi8, om8} !== {8'd1, 3'd0, 1'b0}) begin failures++; $display("FAIL mid_result got=%0d/%0d/%0d exp=1/0/0", od8, oi8, om8); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_n3_min;
    test_tie_mode_alternate;
    test_signed;
    test_bubbles;
    test_backpressure;
    test_random_stream;
    test_reset_midflight;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
